// File: rtl/fp_cvt_d_wu_seq.sv
// Multi-cycle 32-bit unsigned integer to IEEE 754 double converter (FCVT.D.WU).
// Define FP_CVT_D_WU_SIGNED_EN to add the is_signed port for FCVT.D.W.
module fp_cvt_d_wu_seq #(
   parameter int STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] wu,
`ifdef FP_CVT_D_WU_SIGNED_EN
   input  logic        is_signed,
`endif
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] d
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      NORM = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [31:0] mag_reg, mag_next;
   logic [4:0]  exp_cnt_reg, exp_cnt_next;
   logic [63:0] d_reg, d_next;
   logic        sign_reg, sign_next;

   logic        coarse_zero;
   logic [31:0] op_mag;
   logic        op_neg;
   logic [10:0] exp_field;

   // The coarse shift is only taken when the whole top STEP bits are clear,
   // so it can never skip past the leading one.
   generate
      if (STEP > 1) begin : g_coarse
         assign coarse_zero = (mag_reg[31 -: STEP] == '0);
      end else begin : g_fine_only
         assign coarse_zero = 1'b0;
      end
   endgenerate

`ifdef FP_CVT_D_WU_SIGNED_EN
   assign op_neg = is_signed & wu[31];
   assign op_mag = op_neg ? (~wu + 32'd1) : wu;
`else
   assign op_neg = 1'b0;
   assign op_mag = wu;
`endif

   assign exp_field = 11'd1023 + 11'(exp_cnt_reg);

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign d         = d_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg   <= IDLE;
         mag_reg     <= '0;
         exp_cnt_reg <= '0;
         d_reg       <= '0;
         sign_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         mag_reg     <= mag_next;
         exp_cnt_reg <= exp_cnt_next;
         d_reg       <= d_next;
         sign_reg    <= sign_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      mag_next     = mag_reg;
      exp_cnt_next = exp_cnt_reg;
      d_next       = d_reg;
      sign_next    = sign_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               mag_next     = op_mag;
               exp_cnt_next = 5'd31;
               sign_next    = op_neg;
               if (wu == 32'd0) begin
                  // Zero is always +0.0, even for a signed operand
                  d_next     = 64'd0;
                  state_next = DONE;
               end else begin
                  state_next = NORM;
               end
            end
         end
         NORM: begin
            if (mag_reg[31]) begin
               d_next     = {sign_reg, exp_field, mag_reg[30:0], 21'd0};
               state_next = DONE;
            end else if (coarse_zero) begin
               mag_next     = mag_reg << STEP;
               exp_cnt_next = exp_cnt_reg - 5'(STEP);
            end else begin
               mag_next     = mag_reg << 1;
               exp_cnt_next = exp_cnt_reg - 5'd1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_fp_cvt_d_wu_seq.sv
// Directed, table-driven bench for fp_cvt_d_wu_seq at STEP=4.
module tb_fp_cvt_d_wu_seq;

   localparam int STEP = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] wu = 32'd0;
   logic        is_signed = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [63:0] d;

   int n_cmp = 0;
   int n_err = 0;

   fp_cvt_d_wu_seq #(.STEP(STEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .wu        (wu),
`ifdef FP_CVT_D_WU_SIGNED_EN
      .is_signed (is_signed),
`endif
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] op;
      logic        sgn;
      logic [63:0] exp_d;
      int          lat;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // One full transaction: accept, measure latency, check result, consume.
   task automatic do_op(input logic [31:0] op, input logic sgn,
                        input logic [63:0] exp_d, input int exp_lat);
      int lat;
      int wt;
      wt = 0;
      @(negedge clk);
      while (!in_ready && wt < 50) begin
         @(negedge clk);
         wt++;
      end
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      wu        = op;
      is_signed = sgn;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      wu        = $urandom;
      is_signed = ~sgn;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("result_d", d, exp_d);
      chk("in_ready_in_done", 64'(in_ready), 64'd0);
      $display("op wu=0x%08h sgn=%0d -> d=0x%016h lat=%0d", op, sgn, d, lat);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("out_valid_after_hs", 64'(out_valid), 64'd0);
      chk("in_ready_after_hs", 64'(in_ready), 64'd1);
   endtask

   vec_t vecs[$];

   initial begin
      logic [63:0] held_d;
      logic        bad;
      logic [31:0] s_ops[3];
      logic [63:0] s_exp[3];
      int          acc_idx;
      int          res_idx;
      int          cyc;

      vecs.push_back('{32'h0000_0001, 1'b0, 64'h3FF0_0000_0000_0000, 12});
      vecs.push_back('{32'h8000_0000, 1'b0, 64'h41E0_0000_0000_0000, 2});
      vecs.push_back('{32'h0000_0000, 1'b0, 64'h0000_0000_0000_0000, 1});
      vecs.push_back('{32'hFFFF_FFFF, 1'b0, 64'h41EF_FFFF_FFE0_0000, 2});
      vecs.push_back('{32'h0001_2345, 1'b0, 64'h40F2_3450_0000_0000, 8});
      vecs.push_back('{32'h0000_0007, 1'b0, 64'h401C_0000_0000_0000, 10});
      vecs.push_back('{32'h0000_0010, 1'b0, 64'h4030_0000_0000_0000, 11});
      vecs.push_back('{32'h00F0_0000, 1'b0, 64'h416E_0000_0000_0000, 4});
`ifdef FP_CVT_D_WU_SIGNED_EN
      vecs.push_back('{32'hFFFF_FFFF, 1'b1, 64'hBFF0_0000_0000_0000, 12});
      vecs.push_back('{32'h8000_0000, 1'b1, 64'hC1E0_0000_0000_0000, 2});
      vecs.push_back('{32'hFFFF_FFFF, 1'b0, 64'h41EF_FFFF_FFE0_0000, 2});
      vecs.push_back('{32'h0000_0000, 1'b1, 64'h0000_0000_0000_0000, 1});
`endif

      // Reset state
      #2;
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_d", d, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].op, vecs[i].sgn, vecs[i].exp_d, vecs[i].lat);
      end

      // Asynchronous reset in the middle of normalisation
      @(negedge clk);
      in_valid = 1'b1;
      wu       = 32'd1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_d", d, 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst = 1'b0;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) bad = 1'b1;
      end
      chk("midrst_no_result", 64'(bad), 64'd0);
      $display("mid-normalisation reset sequence done");

      // Back-pressure on wu=7
      @(negedge clk);
      in_valid = 1'b1;
      wu       = 32'd7;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 100);
      chk("bp_first_valid", 64'(out_valid), 64'd1);
      held_d = d;
      chk("bp_d", held_d, 64'h401C_0000_0000_0000);
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || in_ready || d !== 64'h401C_0000_0000_0000) bad = 1'b1;
      end
      chk("bp_held_stable", 64'(bad), 64'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      @(negedge clk);
      chk("bp_out_valid_drop", 64'(out_valid), 64'd0);
      chk("bp_in_ready_back", 64'(in_ready), 64'd1);
      $display("back-pressure wu=7 d=0x%016h", held_d);

      // Streaming with in_valid and out_ready held high
      s_ops[0] = 32'd3; s_exp[0] = 64'h4008_0000_0000_0000;
      s_ops[1] = 32'd5; s_exp[1] = 64'h4014_0000_0000_0000;
      s_ops[2] = 32'd0; s_exp[2] = 64'h0000_0000_0000_0000;
      acc_idx = 0;
      res_idx = 0;
      cyc = 0;
      bad = 1'b0;
      out_ready = 1'b1;
      while (res_idx < 3 && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (in_ready && out_valid) bad = 1'b1;
         if (out_valid) begin
            if (res_idx < 3) chk("stream_d", d, s_exp[res_idx]);
            $display("stream result %0d d=0x%016h", res_idx, d);
            res_idx++;
         end
         if (in_ready) begin
            if (acc_idx < 3) begin
               in_valid = 1'b1;
               wu       = s_ops[acc_idx];
               acc_idx++;
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      chk("stream_results", 64'(res_idx), 64'd3);
      chk("stream_accepts", 64'(acc_idx), 64'd3);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) bad = 1'b1;
      end
      chk("stream_no_extra", 64'(bad), 64'd0);
      out_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/fp_cvt_d_wu_seq.md
Name: fp_cvt_d_wu_seq

Overview:
- Multi-cycle converter from a 32-bit unsigned integer to an IEEE 754 double (RISC-V FCVT.D.WU). It is the inverse of the D-to-WU converter in the D-extension ALU.
- Normalises the operand with an iterative leading-zero shifter.
- Uses valid/ready handshakes on input and output.
- Every 32-bit value is exactly representable in a double, so there is no rounding and no flag output.

Parameters:
- STEP, 4, coarse shift amount per NORM cycle. Legal values: 1, 2, 4, 8, 16. With STEP=1 only single-bit shifts occur.

Ports:
- clk  input  1  clock; all state changes on its rising edge
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  operand valid
- in_ready  output  1  converter can accept an operand
- wu  input  32  unsigned integer operand
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- d  output  64  double-precision result

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, d=0, internal mag/exp_cnt=0.
- Asserting rst mid-conversion or while in DONE aborts the operation immediately. The pending result is lost and no out_valid is produced for it.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, register wu into mag[31:0] and set exp_cnt=31. If wu==0, load d=0 and go to DONE. Otherwise go to NORM.
  - NORM: in_ready=0. Exactly one action per cycle, in this priority:
    - If mag[31]==1: load d={1'b0, 11'(1023+exp_cnt), mag[30:0], 21'b0} and go to DONE.
    - Else if STEP>1 and mag[31:32-STEP]==0: mag<<=STEP, exp_cnt-=STEP.
    - Else: mag<<=1, exp_cnt-=1.
  - DONE: out_valid=1, in_ready=0, d held stable. On out_ready go to IDLE. out_valid drops the next cycle.
- Back-pressure: d and out_valid stay constant while out_ready=0, indefinitely.
- in_ready is combinational from state only, never from in_valid or out_ready.
- The converter does not accept a new operand in the same cycle a result is consumed. The next accept is possible one cycle after the DONE handshake.
- Latency L is counted from the accept cycle c to the first out_valid cycle:
  - wu=0: L=1.
  - Otherwise: L = 2 + number of shift cycles.
  - STEP=1: L = 2 + lzc(wu).
  - Worst case at STEP=4: wu=1, 10 shifts, L=12.
- exp_cnt is 5 bits, unsigned, and never underflows because the operand is nonzero. Exponent field = 1023 + exp_cnt, range 1023..1054.
- Sign bit is always 0 unless the optional feature below is enabled.
- Operand wu is sampled only at the accept edge. Later changes on wu have no effect.

Optional Feature:
- Macro: FP_CVT_D_WU_SIGNED_EN
- When defined:
  - Adds input port is_signed (1 bit), sampled with wu at accept (FCVT.D.W).
  - If is_signed=1 and wu[31]=1: mag = two's-complement negation of wu and sign bit = 1.
  - 0x80000000 gives magnitude 2^31, so d=0xC1E0000000000000.
  - Zero always yields +0.0.
- When not defined: no is_signed port. The operand is always unsigned and the sign bit is 0.

Test Plan:
- Reset/idle: assert rst mid-NORM (wu=1 accepted, rst after 3 cycles) -> out_valid=0, d=0, in_ready=1 immediately. No result ever emitted for that operand.
- Basic values, STEP=4:
  - wu=1 -> d=0x3FF0000000000000, L=12.
  - wu=0x80000000 -> d=0x41E0000000000000, L=2.
  - wu=0 -> d=0x0000000000000000, L=1.
- Full-scale and odd value:
  - wu=0xFFFFFFFF -> d=0x41EFFFFFFFE00000, L=2.
  - wu=0x00012345 -> d=0x40F2345000000000, L=2+(3 STEP shifts + 3 single shifts)=8.
- Back-pressure: out_ready=0 for 20 cycles after out_valid on wu=7 -> d=0x401C000000000000 held constant, in_ready=0 throughout. Raising out_ready -> one-cycle handshake, then in_ready=1.
- Streaming: in_valid held high with wu=3,5,0 back-to-back, out_ready=1 -> results 0x4008000000000000, 0x4014000000000000, 0x0 in order, one accept per IDLE visit. No operand dropped or duplicated.
- FP_CVT_D_WU_SIGNED_EN build:
  - is_signed=1, wu=0xFFFFFFFF -> d=0xBFF0000000000000.
  - is_signed=1, wu=0x80000000 -> d=0xC1E0000000000000.
  - is_signed=0, wu=0xFFFFFFFF -> d=0x41EFFFFFFFE00000.
